// File: rtl/dbg_byte_bridge_if.sv
// Byte-stream and debug-module signal bundle for dbg_byte_bridge.
// slave = bridge side, master = host/DM/environment side.
interface dbg_byte_bridge_if;
    logic [7:0]  iRx_data;
    logic        iRx_valid;
    logic        oRx_ready;
    logic [7:0]  oTx_data;
    logic        oTx_valid;
    logic        iTx_ready;
    logic [6:0]  oDm_addr;
    logic [31:0] oDm_wdata;
    logic        oDm_write;
    logic        oDm_req;
    logic [31:0] iDm_rdata;
    logic        iDm_access_valid;
    logic        oReq_halt;
    logic        oReq_resume;
    logic        oStep;
    logic        oEnter_debug;
    logic        iHalted;
    logic        iRunning;
    logic        iStalled;

    modport slave (
        input  iRx_data, iRx_valid, iTx_ready, iDm_rdata, iDm_access_valid,
        input  iHalted, iRunning, iStalled,
        output oRx_ready, oTx_data, oTx_valid, oDm_addr, oDm_wdata, oDm_write, oDm_req,
        output oReq_halt, oReq_resume, oStep, oEnter_debug
    );

    modport master (
        output iRx_data, iRx_valid, iTx_ready, iDm_rdata, iDm_access_valid,
        output iHalted, iRunning, iStalled,
        input  oRx_ready, oTx_data, oTx_valid, oDm_addr, oDm_wdata, oDm_write, oDm_req,
        input  oReq_halt, oReq_resume, oStep, oEnter_debug
    );
endinterface

// File: rtl/dbg_byte_bridge.sv
// Host byte-stream to debug-module bridge: decodes framed READ/WRITE/run-control
// commands, issues one DM access or pulse, and returns a status byte (+ read data).
module dbg_byte_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               iClk,
    input  logic               iRst,
    dbg_byte_bridge_if.slave   bus,
    output logic [2:0]         oDbg_state
);
    // Handshakes: a byte moves on RX when iRx_valid & oRx_ready and on TX when
    // oTx_valid & iTx_ready at a rising edge; oTx_valid/oTx_data hold until then.
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_GET_ADDR    = 3'd1,
        S_GET_DATA    = 3'd2,
        S_ISSUE       = 3'd3,
        S_WAIT        = 3'd4,
        S_RESP_STATUS = 3'd5,
        S_RESP_DATA   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_CTRL  = 2'd2
    } op_t;

    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_BAD_OP  = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] CODE_BAD_ADR = 2'b11;

    state_t        r_state;
    op_t           r_op;
    logic [6:0]    r_addr;
    logic          r_bad_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [1:0]    r_byte_cnt;
    logic [TW-1:0] r_timer;
    logic          r_read_ok;

    logic          r_rx_ready;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;
    logic [6:0]    r_dm_addr;
    logic [31:0]   r_dm_wdata;
    logic          r_dm_write;
    logic          r_dm_req;
    logic          r_halt;
    logic          r_resume;
    logic          r_step;
    logic          r_enter;

    logic          w_rx_fire;
    logic          w_tx_fire;
    logic [2:0]    w_hart;
    logic [31:0]   w_wdata_next;

    assign w_rx_fire    = bus.iRx_valid & r_rx_ready;
    assign w_tx_fire    = r_tx_valid & bus.iTx_ready;
    assign w_hart       = {bus.iStalled, bus.iRunning, bus.iHalted};
    assign w_wdata_next = {bus.iRx_data, r_wdata[31:8]};

    function automatic logic [7:0] status_byte(input logic [1:0] code, input logic [2:0] hart);
        return {code, 3'b000, hart};
    endfunction

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_READ;
            r_addr     <= '0;
            r_bad_addr <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_byte_cnt <= '0;
            r_timer    <= '0;
            r_read_ok  <= 1'b0;
            r_rx_ready <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_dm_write <= 1'b0;
            r_dm_req   <= 1'b0;
            r_halt     <= 1'b0;
            r_resume   <= 1'b0;
            r_step     <= 1'b0;
            r_enter    <= 1'b0;
        end else begin
            r_dm_req <= 1'b0;
            r_halt   <= 1'b0;
            r_resume <= 1'b0;
            r_step   <= 1'b0;
            r_enter  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Ready is registered, so the first IDLE cycle after reset only raises it.
                    if (!r_rx_ready) begin
                        r_rx_ready <= 1'b1;
                    end else if (w_rx_fire) begin
                        case (bus.iRx_data)
                            8'h01: begin
                                r_op    <= OP_READ;
                                r_state <= S_GET_ADDR;
                            end
                            8'h02: begin
                                r_op    <= OP_WRITE;
                                r_state <= S_GET_ADDR;
                            end
                            8'h10, 8'h11, 8'h12, 8'h13: begin
                                r_op       <= OP_CTRL;
                                r_rx_ready <= 1'b0;
                                r_state    <= S_ISSUE;
                                case (bus.iRx_data[1:0])
                                    2'd0:    r_halt   <= 1'b1;
                                    2'd1:    r_resume <= 1'b1;
                                    2'd2:    r_step   <= 1'b1;
                                    default: r_enter  <= 1'b1;
                                endcase
                            end
                            default: begin
                                r_rx_ready <= 1'b0;
                                r_read_ok  <= 1'b0;
                                r_tx_data  <= status_byte(CODE_BAD_OP, w_hart);
                                r_tx_valid <= 1'b1;
                                r_state    <= S_RESP_STATUS;
                            end
                        endcase
                    end
                end
                S_GET_ADDR: begin
                    if (w_rx_fire) begin
                        r_addr     <= bus.iRx_data[6:0];
                        r_bad_addr <= bus.iRx_data[7];
                        if (r_op == OP_WRITE) begin
                            r_byte_cnt <= '0;
                            r_state    <= S_GET_DATA;
                        end else if (bus.iRx_data[7]) begin
                            r_rx_ready <= 1'b0;
                            r_read_ok  <= 1'b0;
                            r_tx_data  <= status_byte(CODE_BAD_ADR, w_hart);
                            r_tx_valid <= 1'b1;
                            r_state    <= S_RESP_STATUS;
                        end else begin
                            r_rx_ready <= 1'b0;
                            r_dm_addr  <= bus.iRx_data[6:0];
                            r_dm_write <= 1'b0;
                            r_dm_req   <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_GET_DATA: begin
                    if (w_rx_fire) begin
                        r_wdata    <= w_wdata_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_rx_ready <= 1'b0;
                            if (r_bad_addr) begin
                                r_read_ok  <= 1'b0;
                                r_tx_data  <= status_byte(CODE_BAD_ADR, w_hart);
                                r_tx_valid <= 1'b1;
                                r_state    <= S_RESP_STATUS;
                            end else begin
                                r_dm_addr  <= r_addr;
                                r_dm_wdata <= w_wdata_next;
                                r_dm_write <= 1'b1;
                                r_dm_req   <= 1'b1;
                                r_state    <= S_ISSUE;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_op == OP_CTRL) begin
                        r_read_ok  <= 1'b0;
                        r_tx_data  <= status_byte(CODE_OK, w_hart);
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP_STATUS;
                    end else begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion in the final counted cycle still beats the timeout.
                    if (bus.iDm_access_valid) begin
                        r_rdata    <= bus.iDm_rdata;
                        r_read_ok  <= (r_op == OP_READ);
                        r_tx_data  <= status_byte(CODE_OK, w_hart);
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP_STATUS;
                    end else if (r_timer == TIMER_LAST) begin
                        r_read_ok  <= 1'b0;
                        r_tx_data  <= status_byte(CODE_TIMEOUT, w_hart);
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP_STATUS;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP_STATUS: begin
                    if (w_tx_fire) begin
                        if (r_read_ok) begin
                            r_tx_data  <= r_rdata[7:0];
                            r_rdata    <= r_rdata >> 8;
                            r_byte_cnt <= '0;
                            r_state    <= S_RESP_DATA;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                S_RESP_DATA: begin
                    if (w_tx_fire) begin
                        if (r_byte_cnt == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_tx_data  <= r_rdata[7:0];
                            r_rdata    <= r_rdata >> 8;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    r_rx_ready <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oRx_ready    = r_rx_ready;
    assign bus.oTx_data     = r_tx_data;
    assign bus.oTx_valid    = r_tx_valid;
    assign bus.oDm_addr     = r_dm_addr;
    assign bus.oDm_wdata    = r_dm_wdata;
    assign bus.oDm_write    = r_dm_write;
    assign bus.oDm_req      = r_dm_req;
    assign bus.oReq_halt    = r_halt;
    assign bus.oReq_resume  = r_resume;
    assign bus.oStep        = r_step;
    assign bus.oEnter_debug = r_enter;
    assign oDbg_state       = r_state;
endmodule

// File: tb/tb_dbg_byte_bridge.sv
// Self-checking bench for dbg_byte_bridge: directed frames plus randomized commands
// compared against a frame-level reference model of the expected response bytes.
module tb_dbg_byte_bridge;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    dbg_byte_bridge_if bif();

    dbg_byte_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .iClk       (clk),
        .iRst       (rst),
        .bus        (bif),
        .oDbg_state (dbg_state)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_req = 0, n_halt = 0, n_resume = 0, n_step = 0, n_enter = 0;
    logic [7:0] exp_q[$];

    // Count high cycles of every strobe; a one-cycle pulse adds exactly one.
    always @(posedge clk) begin
        if (!rst) begin
            if (bif.oDm_req)      n_req++;
            if (bif.oReq_halt)    n_halt++;
            if (bif.oReq_resume)  n_resume++;
            if (bif.oStep)        n_step++;
            if (bif.oEnter_debug) n_enter++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        bif.iRx_data  = b;
        bif.iRx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bif.oRx_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("rx_accept", ok, 1'b1);
        @(negedge clk);
        bif.iRx_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int d, input logic [2:0] hart, input bit bp5);
        bit is_rd, is_wr, is_ctrl, exp_req, ok, prev_pend;
        logic [1:0] code;
        logic [7:0] prev_data;
        int req0, h0, r0, s0, e0, lat, xfers, bp_left;
        bit rdy;

        // Reference model: response bytes follow from opcode, address bit7 and response delay.
        is_rd   = (op == 8'h01);
        is_wr   = (op == 8'h02);
        is_ctrl = (op >= 8'h10 && op <= 8'h13);
        if (is_rd || is_wr) code = addr[7] ? 2'b11 : ((d >= 1 && d <= T) ? 2'b00 : 2'b10);
        else if (is_ctrl)   code = 2'b00;
        else                code = 2'b01;
        exp_req = (is_rd || is_wr) && !addr[7];
        exp_q = {};
        exp_q.push_back({code, 3'b000, hart});
        if (is_rd && code == 2'b00)
            for (int k = 0; k < 4; k++) exp_q.push_back(8'(rdata >> (8 * k)));

        {bif.iStalled, bif.iRunning, bif.iHalted} = hart;
        req0 = n_req; h0 = n_halt; r0 = n_resume; s0 = n_step; e0 = n_enter;

        send_byte(op);
        if (is_rd || is_wr) send_byte(addr);
        if (is_wr) for (int k = 0; k < 4; k++) send_byte(8'(wdata >> (8 * k)));

        if (exp_req) begin
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                if (bif.oDm_req) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            check("dm_req_seen", ok, 1'b1);
            check("dm_addr", bif.oDm_addr, addr[6:0]);
            check("dm_write", bif.oDm_write, is_wr);
            if (is_wr) check("dm_wdata", bif.oDm_wdata, wdata);
            lat = -1;
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                if (lat < 0 && bif.oTx_valid) lat = k + 1;
            end
            if (d > T + 1) check("timeout_latency", lat, T + 1);
            check("dm_addr_hold", bif.oDm_addr, addr[6:0]);
            bif.iDm_rdata        = rdata;
            bif.iDm_access_valid = 1'b1;
            @(negedge clk);
            bif.iDm_access_valid = 1'b0;
            bif.iDm_rdata        = $urandom;
        end

        xfers = 0;
        bp_left = bp5 ? 5 : 0;
        prev_pend = 0;
        prev_data = '0;
        for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if (bp_left > 0 && xfers == 2) begin
                rdy = 0;
                bp_left--;
            end
            if (prev_pend) check("tx_hold", {bif.oTx_valid, bif.oTx_data}, {1'b1, prev_data});
            bif.iTx_ready = rdy;
            if (bif.oTx_valid && rdy) begin
                check("tx_byte", bif.oTx_data, exp_q.pop_front());
                xfers++;
            end
            prev_pend = bif.oTx_valid && !rdy;
            prev_data = bif.oTx_data;
            @(negedge clk);
        end
        bif.iTx_ready = 1'b0;
        check("tx_remaining", exp_q.size(), 0);
        check("tx_idle", bif.oTx_valid, 1'b0);
        check("rx_ready_back", bif.oRx_ready, 1'b1);
        check("strobe_counts",
              {8'(n_req - req0), 8'(n_halt - h0), 8'(n_resume - r0), 8'(n_step - s0), 8'(n_enter - e0)},
              {8'(exp_req), 8'(op == 8'h10), 8'(op == 8'h11), 8'(op == 8'h12), 8'(op == 8'h13)});
    endtask

    initial begin
        logic [7:0] rop;
        logic [7:0] raddr;
        bif.iRx_data = '0;  bif.iRx_valid = 1'b0;  bif.iTx_ready = 1'b0;
        bif.iDm_rdata = '0; bif.iDm_access_valid = 1'b0;
        bif.iHalted = 1'b0; bif.iRunning = 1'b0;   bif.iStalled = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_rx_tx", {bif.oRx_ready, bif.oTx_valid, bif.oTx_data}, '0);
        check("rst_dm", {bif.oDm_req, bif.oDm_write, bif.oDm_addr, bif.oDm_wdata}, '0);
        check("rst_pulses", {bif.oReq_halt, bif.oReq_resume, bif.oStep, bif.oEnter_debug}, '0);
        check("rst_state", dbg_state, 3'd0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(8'h02, 8'h05, 32'hDEADBEEF, 32'h0, 2, 3'b000, 0);
        run_cmd(8'h01, 8'h04, 32'h0, 32'h12345678, 3, 3'b001, 0);
        run_cmd(8'h01, 8'h06, 32'h0, 32'hCAFEF00D, T + 6, 3'b010, 0);
        run_cmd(8'h01, 8'h07, 32'h0, 32'hA5A55A5A, 1, 3'b001, 0);
        run_cmd(8'h01, 8'h08, 32'h0, 32'h01020304, T, 3'b100, 0);
        run_cmd(8'h01, 8'h09, 32'h0, 32'h0BADBEEF, T + 1, 3'b000, 0);
        run_cmd(8'h02, 8'h0A, 32'h11223344, 32'h0, 0, 3'b011, 0);
        run_cmd(8'h10, 8'h00, 32'h0, 32'h0, 0, 3'b000, 0);
        run_cmd(8'h11, 8'h00, 32'h0, 32'h0, 0, 3'b001, 0);
        run_cmd(8'h12, 8'h00, 32'h0, 32'h0, 0, 3'b010, 0);
        run_cmd(8'h13, 8'h00, 32'h0, 32'h0, 0, 3'b111, 0);
        run_cmd(8'h7F, 8'h00, 32'h0, 32'h0, 0, 3'b101, 0);
        run_cmd(8'h00, 8'h00, 32'h0, 32'h0, 0, 3'b000, 0);
        run_cmd(8'h01, 8'h85, 32'h0, 32'h0, 2, 3'b001, 0);
        run_cmd(8'h02, 8'hFF, 32'h55667788, 32'h0, 2, 3'b000, 0);
        run_cmd(8'h01, 8'h7F, 32'h0, 32'h87654321, 4, 3'b001, 1);

        send_byte(8'h02);
        send_byte(8'h05);
        send_byte(8'hAA);
        rst = 1'b1;
        #1;
        check("midrst_rx_tx", {bif.oRx_ready, bif.oTx_valid, bif.oTx_data}, '0);
        check("midrst_dm", {bif.oDm_req, bif.oDm_write, bif.oDm_addr, bif.oDm_wdata}, '0);
        check("midrst_state", dbg_state, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(8'h01, 8'h05, 32'h0, 32'h600DD00D, 2, 3'b001, 0);

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    rop = 8'h01;
                2, 3:    rop = 8'h02;
                4:       rop = 8'(8'h10 + $urandom_range(0, 3));
                default: begin
                    rop = 8'($urandom_range(0, 255));
                    if (rop == 8'h01 || rop == 8'h02 || (rop >= 8'h10 && rop <= 8'h13)) rop = 8'hEE;
                end
            endcase
            raddr = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) raddr[7] = 1'b1;
            run_cmd(rop, raddr, $urandom, $urandom, $urandom_range(0, T + 3),
                    3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit reached");
    end
endmodule
